mcash_req_gen: RTL

Synthesizable request initiator for one mcash cross-bar channel. It generates a pseudo-random sequence of line-aligned load/store requests and drives them onto a channel request port (valid/allowIn/op/addr/data) with strict valid/allowIn flow control. It is instantiated in front of `mcash_ch*_req_*` inputs of the cross bar, so the existing channel monitor and C reference model see and check its traffic.

---
 rtl/mcash_req_gen.sv | 102 ++++++++++
 1 files changed

// File: rtl/mcash_req_gen.sv
// Pseudo-random load/store request initiator for one mcash cross-bar channel.
// Requests follow strict valid/allowIn flow control and are paced by NUM_REQ and GAP.
module mcash_req_gen #(
  parameter int unsigned NUM_REQ = 16,
  parameter int unsigned GAP     = 0,
  parameter logic [31:0] SEED    = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  output logic        req_valid_o,
  input  logic        req_allowIn_i,
  output logic [2:0]  req_op_o,
  output logic [31:0] req_addr_o,
  output logic [63:0] req_data_o,
  output logic        done_o,
  output logic [15:0] issued_cnt_o,
  output logic [15:0] stall_cnt_o
);

  // Handshake: a request transfers on a rising edge where req_valid_o and
  // req_allowIn_i are both high. Once raised, valid stays high and op/addr/data
  // stay frozen until that edge; allowIn while valid is low is ignored.

  localparam logic [31:0] POLY      = 32'h8020_0003;
  localparam logic [15:0] NUM_REQ_L = 16'(NUM_REQ);
  localparam logic [7:0]  GAP_L     = 8'(GAP);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_GAP_WAIT = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] lfsr_q;
  logic [15:0] issued_q;
  logic [15:0] stall_q;
  logic [7:0]  gap_q;

  logic [31:0] lfsr_d;
  logic [15:0] issued_d;

  always_comb begin
    lfsr_d   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);
    issued_d = issued_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED;
      issued_q <= 16'd0;
      stall_q  <= 16'd0;
      gap_q    <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // LFSR is deliberately not reseeded so a restart continues the sequence.
          if (start_i) begin
            state_q  <= S_ISSUE;
            issued_q <= 16'd0;
            stall_q  <= 16'd0;
          end
        end
        S_ISSUE: begin
          if (req_allowIn_i) begin
            lfsr_q   <= lfsr_d;
            issued_q <= issued_d;
            if (issued_d == NUM_REQ_L) begin
              state_q <= S_DONE;
            end else if (GAP_L != 8'd0) begin
              state_q <= S_GAP_WAIT;
              gap_q   <= GAP_L - 8'd1;
            end
          end else if (stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
          end
        end
        S_GAP_WAIT: begin
          if (gap_q == 8'd0) begin
            state_q <= S_ISSUE;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Every output decodes registered state only; allowIn never reaches an output.
  assign req_valid_o  = (state_q == S_ISSUE);
  assign done_o       = (state_q == S_DONE);
  assign req_op_o     = lfsr_q[0] ? 3'd1 : 3'd0;
  assign req_addr_o   = {lfsr_q[31:4], 4'b0000};
  assign req_data_o   = {16'hD47A, issued_q, lfsr_q};
  assign issued_cnt_o = issued_q;
  assign stall_cnt_o  = stall_q;

endmodule
